link_rx_fifo: RTL
=================

Name: link_rx_fifo

Overview:
- Receiver-side stage directly downstream of the link slave in the link_top path.
- Accepts bytes from the upstream sender over a 4-phase req/ack handshake and buffers them in a small FWFT FIFO.
- Presents the buffered bytes to the consumer on a valid/ready interface.
- Also keeps link statistics: last accepted byte, running byte count and mod-256 checksum.

Parameters:
- DATA_W, 8, width of a transferred byte/word.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- AW, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  4-phase request from sender; same clock domain, no synchroniser.
- in_data  input  DATA_W  data from sender; stable while req=1.
- ack  output  1  4-phase acknowledge to sender; registered.
- out_data  output  DATA_W  FIFO head (first-word-fall-through).
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts head this cycle.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- last_byte  output  DATA_W  most recently accepted in_data.
- byte_count  output  8  number of bytes accepted, wraps at 256.
- checksum  output  8  sum mod 256 of the low 8 bits of every accepted byte.

Behaviour:
- Reset (async, immediate):
  - ack=0, FSM=IDLE.
  - FIFO pointers and occupancy = 0, so empty=1, full=0, out_valid=0.
  - last_byte, byte_count and checksum = 0.
  - out_data contents are don't-care while empty.
  - Reset during a handshake drops ack immediately. The sender must restart the transfer. A byte already written is lost.
- Handshake FSM, two states:
  - IDLE (ack=0): if req=1 and full=0 at the clock edge, perform accept and go to ACK. If req=1 and full=1, stay in IDLE with ack=0 and req unanswered (back-pressure).
  - ACK (ack=1): if req=0, set ack<=0 and go to IDLE. Otherwise hold.
  - Accept means: write in_data at wr_ptr, wr_ptr+1, last_byte<=in_data, byte_count+1, checksum<=checksum+in_data[7:0] (8-bit wrap), and ack<=1 at the same edge.
  - Exactly one accept per req pulse. req staying high during ACK never causes a second write.
  - Latency: ack rises 1 clock after req is sampled high with space available, and falls 1 clock after req is sampled low.
- FIFO:
  - A pop occurs when out_valid=1 and out_ready=1 at the edge: rd_ptr+1.
  - out_data = mem[rd_ptr], combinational from registered storage.
  - Pointers wrap modulo DEPTH. Occupancy is tracked with a separate counter of AW+1 bits.
  - Full is evaluated on current occupancy. A pop in the same cycle does not free space for an accept in that cycle; the accept happens the next cycle.
  - Simultaneous accept and pop when 0 < occupancy < DEPTH leaves occupancy unchanged and both pointers advance.
  - Pop while empty is ignored.
- Outputs full, empty and out_valid derive from the occupancy register only, so they are glitch-free.

Test Plan:
- Reset check: assert rst for 3 cycles mid-run -> ack=0, empty=1, full=0, out_valid=0, byte_count=0, checksum=0, last_byte=0 immediately, before the next clock edge.
- Single transfer: with out_ready=0, req=1 and in_data=0xA5 -> ack=1 one cycle later, out_valid=1, out_data=0xA5, last_byte=0xA5, byte_count=1, checksum=0xA5. Then drop req -> ack=0 one cycle later.
- Fill and back-pressure (DEPTH=4, out_ready=0): send 0x01, 0x02, 0x03, 0x04 -> full=1, checksum=0x0A. Fifth req with 0x05 -> ack stays 0. Then pulse out_ready for 1 cycle -> head 0x01 popped, and the next cycle 0x05 is accepted with ack=1. Final FIFO order 0x02, 0x03, 0x04, 0x05; byte_count=5.
- Held req: keep req=1 for 10 cycles after ack -> exactly one write, byte_count increments by 1 only, ack stays 1 until req=0.
- Streaming wrap: out_ready=1, sender loop of 300 bytes with values i mod 256 -> output sequence matches the input in order, byte_count=300 mod 256=44, checksum equals the model sum mod 256, empty=1 at the end, no loss or duplication across pointer wrap.
- Reset mid-handshake: assert rst while ack=1 with 2 bytes buffered -> ack=0 and the FIFO empties at once. After release, the sender restarts with 0x5A -> out_data=0x5A, byte_count=1.

Source files
------------

// File: rtl/link_rx_fifo.sv
// Receiver stage: 4-phase req/ack byte intake into a small FWFT FIFO with a
// valid/ready consumer side, plus link statistics (last byte, count, checksum).
module link_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [DATA_W-1:0] in_data,
   output logic              ack,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] last_byte,
   output logic [7:0]        byte_count,
   output logic [7:0]        checksum
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic              pop;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       occ;
   logic [DATA_W-1:0] mem [DEPTH];

   function automatic logic [7:0] low_byte(input logic [DATA_W-1:0] d);
      return 8'(d);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Full is judged on the current occupancy, so a same-cycle pop never
   // makes room for an accept until the following edge.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (req && !full) state_nxt = S_ACK;
         S_ACK:  if (!req)         state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ack    = (state == S_ACK);
      accept = (state == S_IDLE) && req && !full;
   end

   assign full      = (occ == OCC_FULL);
   assign empty     = (occ == '0);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign out_data  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         case ({accept, pop})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_byte  <= '0;
         byte_count <= '0;
         checksum   <= '0;
      end else if (accept) begin
         last_byte  <= in_data;
         byte_count <= byte_count + 8'd1;
         checksum   <= checksum + low_byte(in_data);
      end
   end

endmodule
